ddr_rd_burst_gen: RTL and testbench

- Sits directly downstream of the per-port DDR read controller. Consumes one read job (queue id + byte count) via valid/ready and turns it into 4 KB-safe AXI4 INCR read bursts on the DDR master.
- Keeps a wrapping read pointer per local queue.
- Pulses a finish strobe once every burst of the job has returned its last beat.
- One instance per uplink port.

---
 rtl/ddr_rd_burst_gen.sv | 150 +++++++++++++++
 tb/tb_ddr_rd_burst_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_gen.sv
// Turns one DDR read job (queue id + byte count) into 4 KB-safe AXI4 INCR read bursts,
// tracking a wrapping read pointer per local queue and pulsing finish once all RLASTs return.
module ddr_rd_burst_gen #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int P_DDR_LOCAL_QUEUE  = 3,
    parameter int P_QUEUE_REGION_AW  = 19,
    parameter int P_MAX_OUTSTANDING  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rd_flag,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_rd_queue,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_byte,
    input  logic                          i_rd_byte_valid,
    output logic                          o_rd_byte_ready,
    output logic                          o_rd_queue_finish,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
    output logic [7:0]                    o_m_axi_arlen,
    output logic [2:0]                    o_m_axi_arsize,
    output logic [1:0]                    o_m_axi_arburst,
    output logic                          o_m_axi_arvalid,
    input  logic                          i_m_axi_arready,
    input  logic                          i_m_axi_rvalid,
    input  logic                          i_m_axi_rlast,
    output logic                          o_m_axi_rready,
    output logic                          o_err
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int RW = AW - 5;
    localparam int NQ = 1 << P_DDR_LOCAL_QUEUE;
    localparam int OW = $clog2(P_MAX_OUTSTANDING + 1);
    localparam logic [2:0] ARSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [P_DDR_LOCAL_QUEUE-1:0] queue_q;
    logic [RW-1:0]                rem_q;
    logic [6:0]                   len_q;
    logic [AW-1:0]                araddr_q;
    logic [7:0]                   arlen_q;
    logic [OW-1:0]                out_q;
    logic [P_QUEUE_REGION_AW-1:0] ptr_q [NQ];
    logic                         finish_q;
    logic                         err_q;
    logic                         run_q;

    logic                         job_hs;
    logic                         ar_hs;
    logic                         r_last;
    logic [RW-1:0]                rem_after;
    logic [AW-1:0]                calc_addr;
    logic [6:0]                   calc_len;

    function automatic logic [RW-1:0] beats_ceil(input logic [AW-1:0] bytes);
        logic [AW:0] sum;
        sum = {1'b0, bytes} + (AW+1)'(63);
        return RW'(sum >> 6);
    endfunction

    // Burst never runs past the end of the current 4 KB page (64 beats of 64 B).
    function automatic logic [6:0] burst_len(input logic [RW-1:0] rem, input logic [5:0] beat_in_page);
        logic [6:0] room;
        room = 7'd64 - {1'b0, beat_in_page};
        return (rem < RW'(room)) ? rem[6:0] : room;
    endfunction

    assign job_hs    = o_rd_byte_ready & i_rd_byte_valid;
    assign ar_hs     = o_m_axi_arvalid & i_m_axi_arready;
    assign r_last    = i_m_axi_rvalid & o_m_axi_rready & i_m_axi_rlast;
    assign rem_after = rem_q - RW'(len_q);
    assign calc_addr = (AW'(queue_q) << P_QUEUE_REGION_AW) | AW'(ptr_q[queue_q]);
    assign calc_len  = burst_len(rem_q, calc_addr[11:6]);

    // Ready is held off during the finish pulse so a new job never overlaps it.
    assign o_rd_byte_ready   = run_q & (state_q == IDLE) & i_rd_flag & ~finish_q;
    assign o_m_axi_arvalid   = (state_q == ISSUE) & (out_q < OW'(P_MAX_OUTSTANDING));
    assign o_m_axi_araddr    = araddr_q;
    assign o_m_axi_arlen     = arlen_q;
    assign o_m_axi_arsize    = ARSIZE;
    assign o_m_axi_arburst   = 2'b01;
    assign o_m_axi_rready    = run_q;
    assign o_rd_queue_finish = finish_q;
    assign o_err             = err_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            finish_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= (state_q == DONE);
            run_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_hs) state_d = (beats_ceil(i_rd_byte) == '0) ? DONE : CALC;
            CALC:    state_d = ISSUE;
            ISSUE:   if (ar_hs) state_d = (rem_after != '0) ? CALC : DRAIN;
            DRAIN:   if (out_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            queue_q  <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            for (int i = 0; i < NQ; i++) ptr_q[i] <= '0;
        end else begin
            if (job_hs) begin
                queue_q <= i_rd_queue;
                rem_q   <= beats_ceil(i_rd_byte);
            end
            if (state_q == CALC) begin
                araddr_q <= calc_addr;
                arlen_q  <= 8'(calc_len - 7'd1);
                len_q    <= calc_len;
            end
            // Pointer wraps naturally at the region size through truncation.
            if (ar_hs) begin
                rem_q           <= rem_after;
                ptr_q[queue_q]  <= ptr_q[queue_q] + P_QUEUE_REGION_AW'({len_q, 6'd0});
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else if (ar_hs && !r_last) begin
            out_q <= out_q + OW'(1);
        end else if (!ar_hs && r_last) begin
            if (out_q == '0) err_q <= 1'b1;
            else             out_q <= out_q - OW'(1);
        end
    end

endmodule

// File: tb/tb_ddr_rd_burst_gen.sv
// Directed bench for ddr_rd_burst_gen: a table of jobs with expected AR bursts plus
// hand sequences for outstanding limit, zero-length jobs, flag gating and reset.
module tb_ddr_rd_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_flag;
    logic [2:0]  rd_queue;
    logic [31:0] rd_byte;
    logic        rd_valid;
    logic        rd_ready;
    logic        finish;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic        err;

    always #5 clk = ~clk;

    ddr_rd_burst_gen dut (
        .i_clk             (clk),
        .i_rst             (rst_n),
        .i_rd_flag         (rd_flag),
        .i_rd_queue        (rd_queue),
        .i_rd_byte         (rd_byte),
        .i_rd_byte_valid   (rd_valid),
        .o_rd_byte_ready   (rd_ready),
        .o_rd_queue_finish (finish),
        .o_m_axi_araddr    (araddr),
        .o_m_axi_arlen     (arlen),
        .o_m_axi_arsize    (arsize),
        .o_m_axi_arburst   (arburst),
        .o_m_axi_arvalid   (arvalid),
        .i_m_axi_arready   (arready),
        .i_m_axi_rvalid    (rvalid),
        .i_m_axi_rlast     (rlast),
        .o_m_axi_rready    (rready),
        .o_err             (err)
    );

    typedef struct {
        logic [2:0]  q;
        logic [31:0] bytes;
        int          n_ar;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] a1;
        logic [7:0]  l1;
        logic [31:0] a2;
        logic [7:0]  l2;
    } vec_t;

    vec_t        vt [11];
    int          checks   = 0;
    int          failures = 0;
    int          ar_cnt   = 0;
    int          fin_cnt  = 0;
    int          pend     = 0;
    int          rel_n    = 0;
    logic        resp_en  = 1'b1;
    logic [31:0] lg_addr [4];
    logic [7:0]  lg_len  [4];
    logic [31:0] hold_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bench cycle: entered at a falling edge, samples, crosses a rising edge,
    // then drives the RLAST responder for the next cycle.
    task automatic cyc();
        #1;
        if (arvalid && arready) begin
            if (ar_cnt < 4) begin
                lg_addr[ar_cnt] = araddr;
                lg_len[ar_cnt]  = arlen;
            end
            ar_cnt++;
            pend++;
        end
        if (finish) begin
            fin_cnt++;
            chk("fin_ready_low", {31'd0, rd_ready}, 32'd0);
            chk("fin_after_all_rlast", {31'd0, (pend == 0) && !rvalid}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        if (pend > 0 && (resp_en || rel_n > 0)) begin
            rvalid = 1'b1;
            rlast  = 1'b1;
            pend--;
            if (!resp_en) rel_n--;
        end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
    endtask

    task automatic run_job(input vec_t v, input int idx);
        int n;
        ar_cnt   = 0;
        fin_cnt  = 0;
        rd_queue = v.q;
        rd_byte  = v.bytes;
        rd_valid = 1'b1;
        #1;
        n = 0;
        while (!rd_ready && n < 50) begin
            cyc();
            n++;
        end
        chk($sformatf("v%0d_accept", idx), {31'd0, rd_ready}, 32'd1);
        cyc();
        rd_valid = 1'b0;
        n = 0;
        while (fin_cnt == 0 && n < 3000) begin
            cyc();
            n++;
        end
        repeat (4) cyc();
        chk($sformatf("v%0d_fin_count", idx), fin_cnt, 1);
        chk($sformatf("v%0d_ar_count", idx), ar_cnt, v.n_ar);
        if (v.n_ar > 0) begin
            chk($sformatf("v%0d_addr0", idx), lg_addr[0], v.a0);
            chk($sformatf("v%0d_len0", idx), {24'd0, lg_len[0]}, {24'd0, v.l0});
        end
        if (v.n_ar > 1) begin
            chk($sformatf("v%0d_addr1", idx), lg_addr[1], v.a1);
            chk($sformatf("v%0d_len1", idx), {24'd0, lg_len[1]}, {24'd0, v.l1});
        end
        if (v.n_ar > 2) begin
            chk($sformatf("v%0d_addr2", idx), lg_addr[2], v.a2);
            chk($sformatf("v%0d_len2", idx), {24'd0, lg_len[2]}, {24'd0, v.l2});
        end
    endtask

    initial begin
        int n;
        vt[0]  = '{3'd2, 32'd200,    1,   32'h0010_0000, 8'd3,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[1]  = '{3'd2, 32'd64,     1,   32'h0010_0100, 8'd0,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[2]  = '{3'd0, 32'd3968,   1,   32'h0000_0000, 8'd61, 32'h0, 8'd0, 32'h0, 8'd0};
        vt[3]  = '{3'd0, 32'd8192,   3,   32'h0000_0F80, 8'd1,  32'h0000_1000, 8'd63, 32'h0000_2000, 8'd61};
        vt[4]  = '{3'd0, 32'd1,      1,   32'h0000_2F80, 8'd0,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[5]  = '{3'd7, 32'd524224, 128, 32'h0038_0000, 8'd63, 32'h0038_1000, 8'd63, 32'h0038_2000, 8'd63};
        vt[6]  = '{3'd7, 32'd128,    2,   32'h003F_FFC0, 8'd0,  32'h0038_0000, 8'd0, 32'h0, 8'd0};
        vt[7]  = '{3'd7, 32'd64,     1,   32'h0038_0040, 8'd0,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[8]  = '{3'd5, 32'd65,     1,   32'h0028_0000, 8'd1,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[9]  = '{3'd3, 32'd63,     1,   32'h0018_0000, 8'd0,  32'h0, 8'd0, 32'h0, 8'd0};
        vt[10] = '{3'd1, 32'd0,      0,   32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0};

        rst_n    = 1'b0;
        rd_flag  = 1'b1;
        rd_queue = 3'd0;
        rd_byte  = 32'd0;
        rd_valid = 1'b0;
        arready  = 1'b1;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_ready", {31'd0, rd_ready}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_finish", {31'd0, finish}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("arsize", {29'd0, arsize}, 32'd6);
        chk("arburst", {30'd0, arburst}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_rready", {31'd0, rready}, 32'd1);
        chk("post_rst_ready", {31'd0, rd_ready}, 32'd1);

        for (int i = 0; i < 11; i++) run_job(vt[i], i);
        chk("table_err", {31'd0, err}, 32'd0);

        // Flag low holds the job off; zero-length job finishes two cycles after accept.
        ar_cnt   = 0;
        fin_cnt  = 0;
        rd_flag  = 1'b0;
        rd_queue = 3'd1;
        rd_byte  = 32'd0;
        rd_valid = 1'b1;
        repeat (5) begin
            cyc();
            #1;
            chk("noflag_ready", {31'd0, rd_ready}, 32'd0);
        end
        chk("noflag_fin", fin_cnt, 0);
        rd_flag = 1'b1;
        #1;
        chk("flag_ready", {31'd0, rd_ready}, 32'd1);
        cyc();
        rd_valid = 1'b0;
        #1;
        chk("zb_fin_c1", {31'd0, finish}, 32'd0);
        cyc();
        #1;
        chk("zb_fin_c2", {31'd0, finish}, 32'd1);
        chk("zb_ready_in_pulse", {31'd0, rd_ready}, 32'd0);
        cyc();
        #1;
        chk("zb_fin_c3", {31'd0, finish}, 32'd0);
        chk("zb_ready_after", {31'd0, rd_ready}, 32'd1);
        chk("zb_ar_count", ar_cnt, 0);

        // Outstanding limit with AR stall, then RLASTs released one at a time.
        resp_en  = 1'b0;
        arready  = 1'b0;
        ar_cnt   = 0;
        fin_cnt  = 0;
        rd_queue = 3'd4;
        rd_byte  = 32'd40960;
        rd_valid = 1'b1;
        #1;
        chk("lim_accept", {31'd0, rd_ready}, 32'd1);
        cyc();
        rd_valid = 1'b0;
        repeat (3) cyc();
        chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
        chk("stall_addr", araddr, 32'h0020_0000);
        chk("stall_len", {24'd0, arlen}, 32'd63);
        hold_addr = araddr;
        repeat (3) begin
            cyc();
            chk("stall_hold_valid", {31'd0, arvalid}, 32'd1);
            chk("stall_hold_addr", araddr, hold_addr);
        end
        arready = 1'b1;
        repeat (20) cyc();
        chk("lim_ar4", ar_cnt, 4);
        chk("lim_arvalid_low", {31'd0, arvalid}, 32'd0);
        chk("lim_no_fin", fin_cnt, 0);
        rel_n = 1;
        repeat (10) cyc();
        chk("lim_ar5", ar_cnt, 5);
        chk("lim_arvalid_low5", {31'd0, arvalid}, 32'd0);
        rel_n = 1;
        repeat (10) cyc();
        chk("lim_ar6", ar_cnt, 6);
        resp_en = 1'b1;
        n = 0;
        while (fin_cnt == 0 && n < 500) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        chk("lim_ar_total", ar_cnt, 10);
        chk("lim_fin", fin_cnt, 1);
        chk("lim_err", {31'd0, err}, 32'd0);

        // Reset mid-drain with two bursts outstanding.
        resp_en  = 1'b0;
        ar_cnt   = 0;
        fin_cnt  = 0;
        rd_queue = 3'd6;
        rd_byte  = 32'd8192;
        rd_valid = 1'b1;
        #1;
        cyc();
        rd_valid = 1'b0;
        repeat (10) cyc();
        chk("drain_ar2", ar_cnt, 2);
        chk("drain_no_fin", fin_cnt, 0);
        pend = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mid_rst_ready", {31'd0, rd_ready}, 32'd0);
        chk("mid_rst_rready", {31'd0, rready}, 32'd0);
        chk("mid_rst_finish", {31'd0, finish}, 32'd0);
        chk("mid_rst_araddr", araddr, 32'h0);
        chk("mid_rst_arlen", {24'd0, arlen}, 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("rst_drop_no_fin", fin_cnt, 0);
        chk("rel_rready", {31'd0, rready}, 32'd1);
        chk("rel_err_clear", {31'd0, err}, 32'd0);
        rvalid = 1'b1;
        rlast  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("stray_rlast_err", {31'd0, err}, 32'd1);
        resp_en = 1'b1;
        run_job(vt[0], 20);
        vt[1] = '{3'd6, 32'd64, 1, 32'h0030_0000, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0};
        run_job(vt[1], 21);
        chk("err_sticky", {31'd0, err}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
